// File: rtl/usb4_tc_noc_fifo_ctrl_8_25.sv
// -----------------------------------------------------------------------------
// usb4_tc_noc_fifo_ctrl_8_25
//
// Show-ahead FIFO controller for an external DEPTH x WIDTH two-port RAM.
// The RAM has a synchronous write port and an asynchronous read port. This
// block drives both RAM ports and presents valid/ready streams on each side.
// Its only state is the two pointers, each with an extra wrap bit, and two
// sticky error flags.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   flush           synchronous clear of both pointers (error flags kept)
//   in_valid/ready  producer handshake, in_data is the producer word
//   out_valid/ready consumer handshake, out_data is the head word
//                   (out_data is zero while empty)
//   ram_wen/waddr/wdata   RAM write port (written on the push edge)
//   ram_ren/raddr/rdata   RAM read port (asynchronous read data)
//   count           occupancy, 0..DEPTH
//   afull           count >= AFULL_LVL
//   err_ovf         sticky: in_valid seen while full
//   err_udf         sticky: out_ready seen while empty
// -----------------------------------------------------------------------------
module usb4_tc_noc_fifo_ctrl_8_25 #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 25,
   parameter int AW        = 3,
   parameter int AFULL_LVL = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             ram_wen,
   output logic [AW-1:0]    ram_waddr,
   output logic [WIDTH-1:0] ram_wdata,
   output logic             ram_ren,
   output logic [AW-1:0]    ram_raddr,
   input  logic [WIDTH-1:0] ram_rdata,
   output logic [AW:0]      count,
   output logic             afull,
   output logic             err_ovf,
   output logic             err_udf
);

   // Threshold held at the pointer-difference width; clamped so an
   // out-of-range level still behaves as "afull only when full".
   localparam int          AFULL_EFF = (AFULL_LVL > DEPTH) ? DEPTH : AFULL_LVL;
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_EFF);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        err_ovf_q, err_ovf_d;
   logic        err_udf_q, err_udf_d;

   logic empty;
   logic full;
   logic push;
   logic pop;

   // Wrap bit distinguishes full (same slot, different lap) from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign ram_wen   = push;
   assign ram_waddr = wr_ptr_q[AW-1:0];
   assign ram_wdata = in_data;
   assign ram_ren   = !empty;
   assign ram_raddr = rd_ptr_q[AW-1:0];

   // Modulo subtraction stays correct across any number of wraps.
   assign count = wr_ptr_q - rd_ptr_q;
   assign afull = (count >= AFULL_CNT);

   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;

   // Gate the head word so the RAM's idle read value never leaks out
   // while the FIFO is empty.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out_gate
         assign out_data[gi] = ram_rdata[gi] & out_valid;
      end
   endgenerate

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      err_ovf_d = err_ovf_q | (in_valid & full);
      err_udf_d = err_udf_q | (out_ready & empty);
      if (flush) begin
         // Handshakes in the flush cycle are discarded.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

endmodule

// File: tb/tb_usb4_tc_noc_fifo_ctrl_8_25.sv
// -----------------------------------------------------------------------------
// Bench for usb4_tc_noc_fifo_ctrl_8_25: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the FIFO. The bench also
// models the external RAM (synchronous write, asynchronous read, all-ones
// when not read-enabled).
// -----------------------------------------------------------------------------
module tb_usb4_tc_noc_fifo_ctrl_8_25;

   localparam int DEPTH = 8;
   localparam int WIDTH = 25;
   localparam int AW    = 3;
   localparam int AFULL = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             ram_wen;
   logic [AW-1:0]    ram_waddr;
   logic [WIDTH-1:0] ram_wdata;
   logic             ram_ren;
   logic [AW-1:0]    ram_raddr;
   logic [WIDTH-1:0] ram_rdata;
   logic [AW:0]      count;
   logic             afull;
   logic             err_ovf;
   logic             err_udf;

   always #5 clk = ~clk;

   usb4_tc_noc_fifo_ctrl_8_25 dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .count(count), .afull(afull), .err_ovf(err_ovf), .err_udf(err_udf)
   );

   // External RAM model.
   logic [WIDTH-1:0] mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem[i] = '1;
   always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;
   assign ram_rdata = ram_ren ? mem[ram_raddr] : '1;

   // Behavioural model: contents as a queue, addresses as running totals.
   logic [WIDTH-1:0] mq[$];
   int unsigned m_wtot, m_rtot;
   bit          m_eovf, m_eudf;
   bit          m_known = 0;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all DUT outputs with the model's view of the current cycle.
   task automatic compare_all();
      int sz;
      sz = mq.size();
      chk("in_ready",  32'(in_ready),  32'(sz < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sz > 0));
      chk("out_data",  32'(out_data),  (sz > 0) ? 32'(mq[0]) : 32'd0);
      chk("count",     32'(count),     32'(sz));
      chk("afull",     32'(afull),     32'(sz >= AFULL));
      chk("ram_wen",   32'(ram_wen),   32'(in_valid && sz < DEPTH));
      chk("ram_waddr", 32'(ram_waddr), m_wtot % DEPTH);
      chk("ram_wdata", 32'(ram_wdata), 32'(in_data));
      chk("ram_ren",   32'(ram_ren),   32'(sz > 0));
      chk("ram_raddr", 32'(ram_raddr), m_rtot % DEPTH);
      chk("err_ovf",   32'(err_ovf),   32'(m_eovf));
      chk("err_udf",   32'(err_udf),   32'(m_eudf));
   endtask

   // One clock cycle: drive at negedge, check mid-cycle, advance model at the edge.
   task automatic step(input bit rn, input bit fl, input bit iv,
                       input logic [WIDTH-1:0] id, input bit ordy);
      bit full_m, empty_m, do_push, do_pop;
      @(negedge clk);
      rst_n = rn; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
      #2;
      if (m_known) compare_all();
      @(posedge clk);
      if (!rn) begin
         mq.delete(); m_wtot = 0; m_rtot = 0; m_eovf = 0; m_eudf = 0;
         m_known = 1;
      end else begin
         full_m  = (mq.size() == DEPTH);
         empty_m = (mq.size() == 0);
         if (iv && full_m)    m_eovf = 1;
         if (ordy && empty_m) m_eudf = 1;
         if (fl) begin
            mq.delete(); m_wtot = 0; m_rtot = 0;
         end else begin
            do_push = iv && !full_m;
            do_pop  = ordy && !empty_m;
            if (do_pop)  begin void'(mq.pop_front()); m_rtot++; end
            if (do_push) begin mq.push_back(id); m_wtot++; end
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;

      // Reset then idle.
      step(0, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      chk("lit_rst_in_ready", 32'(in_ready), 32'd1);
      chk("lit_rst_out_valid", 32'(out_valid), 32'd0);
      chk("lit_rst_out_data", 32'(out_data), 32'd0);
      chk("lit_rst_count", 32'(count), 32'd0);

      // Single push; write address 0 in the push cycle, visible after the edge.
      step(1, 0, 1, 25'h1ABCDE, 0);
      chk("lit_push_out_valid", 32'(out_valid), 32'd1);
      chk("lit_push_out_data", 32'(out_data), 32'h1ABCDE);
      chk("lit_push_count", 32'(count), 32'd1);
      step(1, 0, 0, '0, 1);

      // Fill 8, overflow attempt, drain in order.
      for (int i = 0; i < 8; i++) step(1, 0, 1, 25'(i), 0);
      chk("lit_full_count", 32'(count), 32'd8);
      chk("lit_full_in_ready", 32'(in_ready), 32'd0);
      chk("lit_full_afull", 32'(afull), 32'd1);
      step(1, 0, 1, 25'h55, 0);
      chk("lit_ovf_flag", 32'(err_ovf), 32'd1);
      chk("lit_ovf_count", 32'(count), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("lit_drain_data", 32'(out_data), 32'(i));
         step(1, 0, 0, '0, 1);
      end
      chk("lit_drain_out_valid", 32'(out_valid), 32'd0);

      // Streaming with one word in flight; addresses wrap twice.
      step(0, 0, 0, '0, 0);
      step(1, 0, 1, 25'h100, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 1, 25'(32'h200 + i), 1);
      chk("lit_stream_count", 32'(count), 32'd1);
      chk("lit_stream_head", 32'(out_data), 32'h213);
      step(1, 0, 0, '0, 1);

      // Fill to 5 then flush with both handshakes active.
      for (int i = 0; i < 5; i++) step(1, 0, 1, 25'(32'h300 + i), 0);
      step(1, 1, 1, 25'h3FF, 1);
      chk("lit_flush_count", 32'(count), 32'd0);
      chk("lit_flush_out_valid", 32'(out_valid), 32'd0);
      step(1, 0, 1, 25'h400, 0);
      chk("lit_after_flush_data", 32'(out_data), 32'h400);

      // Mid-stream reset, then underflow.
      step(1, 0, 1, 25'h401, 0);
      step(1, 0, 1, 25'h402, 0);
      step(0, 0, 0, '0, 0);
      chk("lit_rst2_count", 32'(count), 32'd0);
      chk("lit_rst2_err_ovf", 32'(err_ovf), 32'd0);
      chk("lit_rst2_out_valid", 32'(out_valid), 32'd0);
      step(1, 0, 0, '0, 1);
      chk("lit_udf_flag", 32'(err_udf), 32'd1);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 1500; i++) begin
         bit rn, fl, iv, ordy;
         int phase;
         phase = (i / 100) % 3;  // vary fill tendency
         rn   = ($urandom_range(199) != 0);
         fl   = ($urandom_range(59) == 0);
         iv   = (phase == 0) ? ($urandom_range(9) < 8) :
                (phase == 1) ? ($urandom_range(9) < 2) : ($urandom_range(1) == 1);
         ordy = (phase == 0) ? ($urandom_range(9) < 3) :
                (phase == 1) ? ($urandom_range(9) < 8) : ($urandom_range(1) == 1);
         step(rn, fl, iv, 25'($urandom), ordy);
      end
      step(1, 0, 0, '0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
